// File: rtl/add16_seq_ctrl_pkg.sv
// rtl/add16_seq_ctrl_pkg.sv - shared types and constants for the sliced adder sequencer
//   Contents: state_t (IDLE/RUN/HOLD), SLICE_W (adder slice width),
//             width_ok() elaboration-time width/slice consistency check.
package add16_seq_ctrl_pkg;

  // Width of the one physical adder slice; the controller is built around it.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True when the requested operand width can be covered by whole passes of the slice.
  function automatic bit width_ok(input int width, input int slice);
    return (slice == SLICE_W) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/add16_seq_ctrl_adder4.sv
// rtl/add16_seq_ctrl_adder4.sv - 4-bit carry-lookahead adder slice
//   Ports: i_a, i_b [3:0] addends; i_cin carry in;
//          o_sum [3:0] slice sum; o_cout carry out of bit 3.
module add16_seq_ctrl_adder4
  import add16_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // All carries are formed directly from generate/propagate terms and i_cin,
  // so none of them waits on a lower-order carry.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_cout = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/add16_seq_ctrl.sv
// rtl/add16_seq_ctrl.sv - WIDTH-bit adder time-sharing one 4-bit slice, LSB slice first
//   Ports: clk, rst (async, active-high);
//          in_valid/in_ready + a, b, cin  : operand handshake;
//          out_valid/out_ready + sum, cout, ovf : result handshake (held in HOLD);
//          busy : controller not idle.
module add16_seq_ctrl
  import add16_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
      $error("add16_seq_ctrl: WIDTH must be a positive multiple of SLICE, and SLICE must be 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  // Operands are only sampled on an accept, so anything on a/b while
  // in_valid is low never reaches the registers.
  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_step   = (r_state == ST_RUN);
  assign w_last   = (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Shared slice datapath
  // ---------------------------------------------------------------------------
  assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];

  add16_seq_ctrl_adder4 u_adder4 (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_slice_sum;
      r_carry <= w_slice_cout;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice_cout;
        // The top sum bit is being written on this same edge, so it is taken
        // from the slice output rather than from r_sum.
        r_ovf  <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_slice_sum[SLICE_W-1] ^ r_a[WIDTH-1]);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// tb/tb_add16_seq_ctrl.sv - scoreboard testbench for add16_seq_ctrl
module tb_add16_seq_ctrl;

  localparam int W   = 16;
  localparam int LAT = 5;  // negedge sample of accept -> first negedge with out_valid

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  always #5 clk = ~clk;

  add16_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   b2b = 1'b0;
  int   b2b_cnt = 0;

  logic         pv = 1'b0;
  logic [W-1:0] ps = '0;
  logic         pc = 1'b0;
  logic         po = 1'b0;
  bit           idle_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition in W+1 bits, signed overflow by sign rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int acc);
    exp_t e;
    logic [W:0] t;
    t     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.v   = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.acc = acc;
    return e;
  endfunction

  // Input monitor: every accepted operand set yields one expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      if (b2b) begin
        if (b2b_cnt > 0) chk("accept_spacing", cyc - last_acc, 6);
        b2b_cnt++;
      end
      last_acc = cyc;
      sb.push_back(model(a, b, cin, cyc));
    end
  end

  // Output monitor: latency, hold stability, result compare on consume.
  always @(negedge clk) begin
    if (rst) begin
      pv        = 1'b0;
      idle_next = 1'b0;
    end else begin
      if (idle_next) begin
        chk("post_consume_busy", busy, 0);
        chk("post_consume_in_ready", in_ready, 1);
        idle_next = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
        end else begin
          if (!pv) begin
            chk("latency", cyc - sb[0].acc, LAT);
          end else begin
            chk("hold_sum_stable", sum, ps);
            chk("hold_cout_stable", cout, pc);
            chk("hold_ovf_stable", ovf, po);
          end
          chk("hold_in_ready", in_ready, 0);
          if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
            chk("ovf", ovf, e.v);
            idle_next = 1'b1;
          end
        end
      end
      pv = out_valid;
      ps = sum;
      pc = cout;
      po = ovf;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n;
    n = 0;
    a = x;
    b = y;
    cin = ci;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic         xc;

    // Reset values
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Garbage on a/b with in_valid low must not start or disturb anything
    repeat (4) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("idle_busy", busy, 0);
    chk("idle_sum", sum, 0);
    chk("idle_out_valid", out_valid, 0);

    // Directed arithmetic cases
    send(16'h1234, 16'h4321, 1'b0); in_valid = 1'b0; drain();
    send(16'hFFFF, 16'h0001, 1'b0); in_valid = 1'b0; drain();
    send(16'hFFFF, 16'h0000, 1'b1); in_valid = 1'b0; drain();
    send(16'h7FFF, 16'h0001, 1'b0); in_valid = 1'b0; drain();
    send(16'h8000, 16'h8000, 1'b0); in_valid = 1'b0; drain();

    // Backpressure: result held, new request ignored until consumed
    out_ready = 1'b0;
    send(16'h00FF, 16'h0101, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    xa = 16'h0F0F;
    xb = W'($urandom);
    xc = 1'($urandom);
    @(posedge clk);
    #1;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_request_ignored", sb.size(), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(xa, xb, xc);
    in_valid = 1'b0;
    drain();

    // Reset mid-RUN: discard in-flight sum, no out_valid afterwards
    send(16'hAAAA, 16'h5555, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("post_rst_no_out_valid", bad, 0);
    send(16'h0001, 16'h0001, 1'b0); in_valid = 1'b0; drain();

    // Back-to-back random traffic
    out_ready = 1'b1;
    b2b = 1'b1;
    b2b_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    drain();
    b2b = 1'b0;
    chk("b2b_accepts", b2b_cnt, 8);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
